// File: rtl/bsg_counter_up_down.sv
// Up/down counter that moves by at most max_step_p per cycle in each direction.
// It does not clamp; the caller keeps the result within [0, max_val_p].
module bsg_counter_up_down #(
    parameter int unsigned max_val_p  = 256,
    parameter int unsigned init_val_p = 256,
    parameter int unsigned max_step_p = 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [$clog2(max_step_p+1)-1:0]    up_i,
    input  logic [$clog2(max_step_p+1)-1:0]    down_i,
    output logic [$clog2(max_val_p+1)-1:0]     count_o
);

    localparam int unsigned ptr_width_lp = $clog2(max_val_p + 1);

    logic [ptr_width_lp-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= ptr_width_lp'(init_val_p);
        end else begin
            r_count <= r_count - ptr_width_lp'(down_i) + ptr_width_lp'(up_i);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bsg_fifo_credit_sender.sv
// Credit-based sender: forwards client data onto a valid-only link, spending one
// credit per transfer and regaining credit_decimation_p credits per credit_i pulse.
module bsg_fifo_credit_sender #(
    parameter int unsigned width_p             = 32,
    parameter int unsigned els_p               = 256,
    parameter int unsigned credit_decimation_p = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    input  logic [width_p-1:0]            data_i,
    output logic                          ready_o,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          credit_i,
    output logic [$clog2(els_p+1)-1:0]    credit_count_o,
    output logic                          error_o
);

    localparam int unsigned cnt_w_lp  = $clog2(els_p + 1);
    // One extra bit so count + credit can exceed els_p without wrapping.
    localparam int unsigned ext_w_lp  = cnt_w_lp + 1;
    localparam int unsigned step_w_lp = $clog2(credit_decimation_p + 1);
    localparam logic [ext_w_lp-1:0] els_ext_lp = ext_w_lp'(els_p);
    localparam logic [ext_w_lp-1:0] dec_ext_lp = ext_w_lp'(credit_decimation_p);

    logic [cnt_w_lp-1:0]  w_count;
    logic                 w_ready;
    logic                 w_xfer;
    logic                 w_overflow;
    logic [ext_w_lp-1:0]  w_credit_amt;
    logic [ext_w_lp-1:0]  w_next;
    logic [ext_w_lp-1:0]  w_up_ext;
    logic [step_w_lp-1:0] w_up;
    logic [step_w_lp-1:0] w_down;

    logic                 r_v;
    logic [width_p-1:0]   r_data;
    logic                 r_error;

    always_comb begin
        w_ready      = (w_count != '0) && !reset_i;
        w_xfer       = v_i && w_ready;
        w_credit_amt = credit_i ? dec_ext_lp : '0;
        w_next       = ext_w_lp'(w_count) - ext_w_lp'(w_xfer) + w_credit_amt;
        w_overflow   = w_next > els_ext_lp;
        // On overflow, add only what lands the count exactly on els_p.
        w_up_ext     = w_overflow
                     ? (els_ext_lp - ext_w_lp'(w_count) + ext_w_lp'(w_xfer))
                     : w_credit_amt;
        w_up         = step_w_lp'(w_up_ext);
        w_down       = step_w_lp'(w_xfer);
    end

    bsg_counter_up_down #(
        .max_val_p  (els_p),
        .init_val_p (els_p),
        .max_step_p (credit_decimation_p)
    ) u_credit_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .up_i    (w_up),
        .down_i  (w_down),
        .count_o (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v     <= 1'b0;
            r_data  <= '0;
            r_error <= 1'b0;
        end else begin
            r_v <= w_xfer;
            if (w_xfer) begin
                r_data <= data_i;
            end
            if (w_overflow) begin
                r_error <= 1'b1;
            end
        end
    end

    assign ready_o        = w_ready;
    assign v_o            = r_v;
    assign data_o         = r_data;
    assign credit_count_o = w_count;
    assign error_o        = r_error;

endmodule

// File: tb/tb_bsg_fifo_credit_sender.sv
// Directed and randomized checks for bsg_fifo_credit_sender; a second instance
// runs with credit_decimation_p=4 to exercise saturation.
module tb_bsg_fifo_credit_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: els 256, decimation 1
    logic        reset_i, v_i, credit_i;
    logic [31:0] data_i;
    logic        ready_o, v_o, error_o;
    logic [31:0] data_o;
    logic [8:0]  count_o;

    // Instance B: els 256, decimation 4
    logic        b_reset, b_v, b_credit;
    logic [31:0] b_data;
    logic        b_ready, b_v_o, b_error;
    logic [31:0] b_data_o;
    logic [8:0]  b_count;

    bsg_fifo_credit_sender #(
        .width_p             (32),
        .els_p               (256),
        .credit_decimation_p (1)
    ) u_dut_a (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .credit_i       (credit_i),
        .credit_count_o (count_o),
        .error_o        (error_o)
    );

    bsg_fifo_credit_sender #(
        .width_p             (32),
        .els_p               (256),
        .credit_decimation_p (4)
    ) u_dut_b (
        .clk_i          (clk),
        .reset_i        (b_reset),
        .v_i            (b_v),
        .data_i         (b_data),
        .ready_o        (b_ready),
        .v_o            (b_v_o),
        .data_o         (b_data_o),
        .credit_i       (b_credit),
        .credit_count_o (b_count),
        .error_o        (b_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          pulses;
        int          m_cnt;
        int          max_occ;
        int          credit_thr;
        logic        prev_xfer;
        logic        xfer;
        logic [31:0] last_data;
        logic [31:0] rx[$];

        reset_i = 1'b1; v_i = 1'b0; credit_i = 1'b0; data_i = '0;
        b_reset = 1'b1; b_v = 1'b0; b_credit = 1'b0; b_data = '0;
        #1;
        check("rst_ready_comb", ready_o, 0);
        step();
        credit_i = 1'b1;
        step();
        check("rst_count", count_o, 256);
        check("rst_v", v_o, 0);
        check("rst_err", error_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_b_count", b_count, 256);
        reset_i = 1'b0; b_reset = 1'b0; credit_i = 1'b0;
        #1;
        check("post_rst_ready", ready_o, 1);

        // Drain all 256 credits with no returns.
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            v_i    = 1'b1;
            data_i = 32'hA500_0000 + k;
            step();
            if (v_o) pulses++;
            check("drain_v", v_o, (k < 256) ? 1 : 0);
            check("drain_data", data_o, (k < 256) ? 32'hA500_0000 + k : 32'hA500_00FF);
            if (k == 99) check("drain_cnt_mid", count_o, 156);
        end
        check("drain_pulses", pulses, 256);
        check("drain_cnt", count_o, 0);
        check("drain_ready", ready_o, 0);

        // Credit arriving at count 0 does not allow a same-cycle transfer.
        data_i = 32'hC0DE_0001; v_i = 1'b1; credit_i = 1'b1;
        #1;
        check("zero_ready", ready_o, 0);
        step();
        credit_i = 1'b0;
        check("zero_no_xfer", v_o, 0);
        check("zero_cnt1", count_o, 1);
        check("zero_ready_rise", ready_o, 1);
        step();
        check("zero_xfer_v", v_o, 1);
        check("zero_xfer_data", data_o, 32'hC0DE_0001);
        check("zero_cnt0", count_o, 0);
        check("zero_ready_fall", ready_o, 0);
        v_i = 1'b0;

        // Simultaneous transfer and credit at count 10.
        credit_i = 1'b1;
        repeat (10) step();
        check("cnt10", count_o, 10);
        v_i = 1'b1; data_i = 32'h1234_5678;
        step();
        check("simul_cnt", count_o, 10);
        check("simul_v", v_o, 1);
        check("simul_data", data_o, 32'h1234_5678);
        v_i = 1'b0; credit_i = 1'b0;
        step();
        check("idle_v", v_o, 0);
        check("idle_data_hold", data_o, 32'h1234_5678);
        check("idle_cnt", count_o, 10);

        // Decimation 4: 256 -> 250 -> 254 -> saturate at 256 with sticky error.
        b_v = 1'b1; b_data = 32'hB000_0000;
        repeat (6) step();
        b_v = 1'b0;
        check("b_cnt250", b_count, 250);
        b_credit = 1'b1;
        step();
        check("b_cnt254", b_count, 254);
        check("b_err0", b_error, 0);
        step();
        check("b_sat", b_count, 256);
        check("b_err1", b_error, 1);
        b_credit = 1'b0;
        step();
        check("b_sat_hold", b_count, 256);
        check("b_err_hold", b_error, 1);
        b_v = 1'b1;
        step();
        b_v = 1'b0;
        check("b_cnt255", b_count, 255);
        check("b_err_sticky", b_error, 1);

        // Reset during a burst discards the in-flight beat.
        credit_i = 1'b1;
        repeat (90) step();
        credit_i = 1'b0;
        check("cnt100", count_o, 100);
        for (int i = 0; i < 3; i++) begin
            v_i = 1'b1; data_i = 32'hD000_0000 + i;
            step();
        end
        check("burst_v", v_o, 1);
        check("burst_cnt", count_o, 97);
        reset_i = 1'b1;
        #1;
        check("mid_rst_ready", ready_o, 0);
        step();
        check("mid_rst_v", v_o, 0);
        check("mid_rst_cnt", count_o, 256);
        check("mid_rst_err", error_o, 0);
        check("mid_rst_data", data_o, 0);
        step();
        check("mid_rst_v2", v_o, 0);
        reset_i = 1'b0;
        #1;
        check("mid_rst_ready_after", ready_o, 1);
        v_i = 1'b0;

        // Overflow at decimation 1.
        credit_i = 1'b1;
        step();
        check("a_sat", count_o, 256);
        check("a_err1", error_o, 1);
        credit_i = 1'b0;
        step();
        check("a_err_hold", error_o, 1);
        reset_i = 1'b1;
        step();
        check("a_err_clr", error_o, 0);
        reset_i = 1'b0;

        // Random traffic against a 256-entry receiver model.
        m_cnt     = 256;
        max_occ   = 0;
        prev_xfer = 1'b0;
        last_data = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (v_o) rx.push_back(data_o);
            check("rnd_v", v_o, prev_xfer);
            if (prev_xfer) check("rnd_data", data_o, last_data);
            if (rx.size() > max_occ) max_occ = rx.size();
            credit_thr = (cyc < 5000) ? 1 : 3;
            v_i    = 1'($urandom_range(0, 1));
            data_i = $urandom;
            if (rx.size() > 0 && $urandom_range(0, 3) < credit_thr) begin
                void'(rx.pop_front());
                credit_i = 1'b1;
            end else begin
                credit_i = 1'b0;
            end
            #1;
            check("rnd_ready", ready_o, (m_cnt != 0) ? 1 : 0);
            xfer      = v_i && (m_cnt != 0);
            prev_xfer = xfer;
            if (xfer) last_data = data_i;
            m_cnt = m_cnt - (xfer ? 1 : 0) + (credit_i ? 1 : 0);
            step();
        end
        v_i = 1'b0; credit_i = 1'b0;
        check("rnd_cnt", count_o, m_cnt);
        check("rnd_err", error_o, 0);
        check("rnd_occ", (max_occ <= 256) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
